alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU_32bit instance between two requesters (port 0, port 1).
- Each requester issues operand/opcode transactions over a valid/ready request channel and receives its result over a valid/ready response channel.
- Arbitration is round-robin. At most one operation is in flight at a time.
- Sits between requester blocks and the ALU; drives the ALU's a, b, c inputs and samples its y output.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU data width.
- OPW, 2, opcode width; must match the ALU select width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  arbiter accepts requester 0 operation this cycle.
- req0_a  in  WIDTH  operand a, requester 0.
- req0_b  in  WIDTH  operand b, requester 0.
- req0_op  in  OPW  ALU opcode, requester 0.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as above for requester 1.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 takes result.
- rsp0_y  out  WIDTH  result, requester 0.
- rsp1_valid, rsp1_ready, rsp1_y: same for requester 1.
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_c  out  OPW  to ALU c.
- alu_y  in  WIDTH  from ALU y.
- busy  out  1  high when state != IDLE.

Behaviour:
- ALU opcode meaning (bench reference model):
  - 00 = a+b (mod 2^WIDTH).
  - 01 = a-b (mod 2^WIDTH).
  - 10 = a&b.
  - 11 = a|b.
  - The arbiter never interprets op; it passes it through.
- Registers:
  - state: IDLE/EXEC/RESP.
  - grant: 1 bit, owner of current op.
  - prio: 1 bit, requester with priority next.
  - op_a, op_b, op_c: operand registers; drive alu_a/alu_b/alu_c directly.
  - res: result register; drives both rsp0_y and rsp1_y.
- Reset (rst=1 at clock edge):
  - state=IDLE, prio=0, grant=0, op_a=op_b=0, op_c=0, res=0.
  - Outputs: req*_ready=0, rsp*_valid=0, busy=0, alu_*=0, rsp*_y=0.
  - Reset mid-operation abandons the op; no response is ever produced for it.
- IDLE:
  - If only reqN_valid is high, select N.
  - If both are high, select prio.
  - req<sel>_ready = 1 combinationally in the same cycle. The other ready stays 0.
  - On that edge: op_a/op_b/op_c <= selected operands, grant <= sel, state -> EXEC.
  - No valid: stay IDLE; all readies 0.
  - Readies are 0 in every state other than IDLE.
- EXEC (one cycle):
  - ALU inputs are stable from the registers.
  - On the edge: res <= alu_y, state -> RESP.
- RESP:
  - rsp<grant>_valid=1; the other rsp_valid=0.
  - res is held until rsp<grant>_ready=1 at an edge.
  - On that edge: state -> IDLE, prio <= ~grant.
  - rsp_ready of the non-granted port is ignored.
- Latency and throughput:
  - Request handshake at edge T gives rsp_valid high from T+2.
  - Minimum 3 cycles per op with back-to-back ready.
- Fairness:
  - With both requesters continuously valid, grants alternate 0,1,0,1...
  - A requester waits at most one other op.
- op_a/op_b/op_c change only on an IDLE accept, so alu_* hold their last operands while idle.
- Requesters must hold valid and payload until ready. The arbiter samples the payload only in the accept cycle.

Test Plan:
- Reset: assert rst 2 cycles with req0_valid=1 -> req0_ready=0, rsp*_valid=0, busy=0, alu_a=0 throughout; after release, first accept in the next IDLE cycle.
- Single op: req0 a=0xFFFFFFFB, b=0x00000003, op=00, rsp0_ready=1 -> ready at T, rsp0_valid at T+2 with rsp0_y=0xFFFFFFFE, rsp1_valid stays 0.
- All opcodes via req1, same operands -> rsp1_y = 0xFFFFFFFE (00), 0xFFFFFFF8 (01), 0x00000003 (10), 0xFFFFFFFB (11).
- Contention: both valid continuously from reset, 4 ops, ready tied high -> grant order 0,1,0,1; each op 3 cycles; results routed to the correct port.
- Backpressure: rsp0_ready=0 for 5 cycles in RESP -> rsp0_valid and rsp0_y held stable, req1_ready stays 0, busy=1; raise ready -> IDLE next cycle, req1 granted.
- Reset mid-op: assert rst in EXEC -> next cycle state IDLE, no rsp_valid pulse, prio=0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Request/response handshake bundle for two ALU requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 2
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_y;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_y;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_y,
        input  req1_ready, rsp1_valid, rsp1_y
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_y,
        output req1_ready, rsp1_valid, rsp1_y
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin sharing of one combinational ALU between two
//                requesters, one operation in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    alu_arbiter_if.slave          bus,
    output      logic [WIDTH-1:0] alu_a,
    output      logic [WIDTH-1:0] alu_b,
    output      logic [OPW-1:0]   alu_c,
    input  wire logic [WIDTH-1:0] alu_y,
    output      logic             busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             prio_q,  prio_d;
    logic [WIDTH-1:0] op_a_q,  op_a_d;
    logic [WIDTH-1:0] op_b_q,  op_b_d;
    logic [OPW-1:0]   op_c_q,  op_c_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic             sel;
    logic             accept;
    logic             rsp_fire;

    always_comb begin
        sel      = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
        // Readies are gated by rst so nothing looks accepted during reset.
        accept   = (state_q == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
        rsp_fire = grant_q ? bus.rsp1_ready : bus.rsp0_ready;

        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        op_c_d  = op_c_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                    grant_d = sel;
                    op_a_d  = sel ? bus.req1_a  : bus.req0_a;
                    op_b_d  = sel ? bus.req1_b  : bus.req0_b;
                    op_c_d  = sel ? bus.req1_op : bus.req0_op;
                end
            end
            EXEC: begin
                res_d   = alu_y;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_fire) begin
                    state_d = IDLE;
                    prio_d  = ~grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            op_c_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            op_c_q  <= op_c_d;
            res_q   <= res_d;
        end
    end

    assign bus.req0_ready = accept && !sel;
    assign bus.req1_ready = accept &&  sel;
    assign bus.rsp0_valid = (state_q == RESP) && !grant_q;
    assign bus.rsp1_valid = (state_q == RESP) &&  grant_q;
    assign bus.rsp0_y     = res_q;
    assign bus.rsp1_y     = res_q;
    assign alu_a          = op_a_q;
    assign alu_b          = op_b_q;
    assign alu_c          = op_c_q;
    assign busy           = (state_q != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Scoreboard bench for alu_arbiter with a behavioural ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    localparam int WIDTH = 32;
    localparam int OPW   = 2;

    typedef struct packed {
        logic        vld;
        logic        port;
        logic [31:0] y;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_c;
    logic [WIDTH-1:0] alu_y;
    logic             busy;
    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;
    exp_t             sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .alu_a (alu_a),
        .alu_b (alu_b),
        .alu_c (alu_c),
        .alu_y (alu_y),
        .busy  (busy)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_y = alu_ref(alu_a, alu_b, alu_c);

    function automatic exp_t pop_exp();
        exp_t e;
        e = '0;
        if (sb.size() != 0) e = sb.pop_front();
        return e;
    endfunction

    task automatic push_exp(input logic port, input logic [31:0] y);
        exp_t e;
        e.vld  = 1'b1;
        e.port = port;
        e.y    = y;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
    endtask

    task automatic drive_req(input logic port, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] op);
        if (!port) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
    endtask

    // Holds the request until accepted; acc_edge is the cyc value after the accept edge.
    task automatic send(input logic port, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] exp_y,
                        output bit ok, output int acc_edge);
        ok = 1'b0;
        acc_edge = -1;
        drive_req(port, a, b, op);
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((port ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                push_exp(port, exp_y);
                acc_edge = cyc + 1;
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        if (!port) bus.req0_valid = 1'b0;
        else       bus.req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok, output logic port, output logic [31:0] y,
                            output int rsp_cyc);
        ok = 1'b0; port = 1'b0; y = '0; rsp_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.rsp0_valid === 1'b1 || bus.rsp1_valid === 1'b1) begin
                ok      = 1'b1;
                port    = bus.rsp1_valid;
                y       = bus.rsp1_valid ? bus.rsp1_y : bus.rsp0_y;
                rsp_cyc = cyc;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        bit ok; int acc; int c; int rc; logic p; logic [31:0] y; exp_t e;
        idle_inputs();
        rst = 1'b1;
        drive_req(1'b0, 32'h1234_5678, 32'h0000_0001, 2'b00);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({bus.req0_ready, bus.rsp0_valid, bus.rsp1_valid, busy} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ctrl: got ready/rv0/rv1/busy=%b want 0000",
                         {bus.req0_ready, bus.rsp0_valid, bus.rsp1_valid, busy});
            end
            checks++;
            if ({alu_a, alu_b, alu_c, bus.rsp0_y, bus.rsp1_y} !== '0) begin
                errors++;
                $display("FAIL reset_data: got alu_a=%h alu_b=%h alu_c=%b y0=%h y1=%h want all 0",
                         alu_a, alu_b, alu_c, bus.rsp0_y, bus.rsp1_y);
            end
        end
        rst = 1'b0;
        c = cyc;
        send(1'b0, 32'h1234_5678, 32'h0000_0001, 2'b00, 32'h1234_5679, ok, acc);
        checks++;
        if (!ok || acc != c + 1) begin
            errors++;
            $display("FAIL reset_first_accept: got accept edge %0d want %0d", acc, c + 1);
        end
        wait_rsp(ok, p, y, rc);
        e = pop_exp();
        checks++;
        if (!ok || !e.vld || p !== e.port || y !== e.y) begin
            errors++;
            $display("FAIL reset_first_rsp: got port=%b y=%h want port=%b y=%h", p, y, e.port, e.y);
        end
        step();
    endtask

    task automatic test_single_op();
        bit ok; int acc; int rc; logic p; logic [31:0] y; exp_t e;
        send(1'b0, 32'hFFFF_FFFB, 32'h0000_0003, 2'b00, 32'hFFFF_FFFE, ok, acc);
        wait_rsp(ok, p, y, rc);
        checks++;
        if (!ok || rc != acc + 1) begin
            errors++;
            $display("FAIL single_latency: got rsp cycle %0d want %0d", rc, acc + 1);
        end
        checks++;
        if (bus.rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp1_quiet: got rsp1_valid=%b want 0", bus.rsp1_valid);
        end
        e = pop_exp();
        checks++;
        if (!ok || !e.vld || p !== e.port || y !== e.y) begin
            errors++;
            $display("FAIL single_result: got port=%b y=%h want port=%b y=%h", p, y, e.port, e.y);
        end
        step();
    endtask

    task automatic test_opcodes();
        bit ok; int acc; int rc; logic p; logic [31:0] y; exp_t e;
        logic [31:0] exp_tab [4];
        exp_tab = '{32'hFFFF_FFFE, 32'hFFFF_FFF8, 32'h0000_0003, 32'hFFFF_FFFB};
        for (int k = 0; k < 4; k++) begin
            send(1'b1, 32'hFFFF_FFFB, 32'h0000_0003, 2'(k), exp_tab[k], ok, acc);
            wait_rsp(ok, p, y, rc);
            e = pop_exp();
            checks++;
            if (!ok || !e.vld || p !== e.port || y !== e.y) begin
                errors++;
                $display("FAIL opcode_%0d: got port=%b y=%h want port=%b y=%h",
                         k, p, y, e.port, e.y);
            end
            step();
        end
    endtask

    task automatic test_contention();
        logic [31:0] pa [2];
        logic [31:0] pb [2];
        logic [1:0]  pop_code [2];
        int n_acc = 0; int n_rsp = 0; int last_acc = -1;
        logic g; logic acc_now; exp_t e; logic p; logic [31:0] y;
        idle_inputs();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            pa[k] = $urandom; pb[k] = $urandom; pop_code[k] = 2'($urandom_range(0, 3));
            drive_req(k[0], pa[k], pb[k], pop_code[k]);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 60 && n_rsp < 4; i++) begin
            #1;
            acc_now = 1'b0;
            g = 1'b0;
            if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
                g = bus.req1_ready;
                acc_now = 1'b1;
                checks++;
                if ({bus.req1_ready, bus.req0_ready} !== (n_acc[0] ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL contention_grant_%0d: got ready1/0=%b want grant %0d",
                             n_acc, {bus.req1_ready, bus.req0_ready}, n_acc % 2);
                end
                if (n_acc > 0) begin
                    checks++;
                    if (cyc - last_acc != 3) begin
                        errors++;
                        $display("FAIL contention_spacing: got %0d cycles want 3", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                push_exp(g, alu_ref(pa[g], pb[g], pop_code[g]));
                n_acc++;
            end
            if (bus.rsp0_valid === 1'b1 || bus.rsp1_valid === 1'b1) begin
                p = bus.rsp1_valid;
                y = p ? bus.rsp1_y : bus.rsp0_y;
                e = pop_exp();
                checks++;
                if (!e.vld || p !== e.port || y !== e.y) begin
                    errors++;
                    $display("FAIL contention_rsp_%0d: got port=%b y=%h want port=%b y=%h",
                             n_rsp, p, y, e.port, e.y);
                end
                n_rsp++;
            end
            step();
            if (acc_now) begin
                pa[g] = $urandom; pb[g] = $urandom; pop_code[g] = 2'($urandom_range(0, 3));
                drive_req(g, pa[g], pb[g], pop_code[g]);
                if (n_acc == 4) begin
                    bus.req0_valid = 1'b0;
                    bus.req1_valid = 1'b0;
                end
            end
        end
        checks++;
        if (n_rsp != 4) begin
            errors++;
            $display("FAIL contention_timeout: got %0d responses want 4", n_rsp);
        end
        step();
    endtask

    task automatic test_backpressure();
        bit ok; int rc; logic p; logic [31:0] y; logic [31:0] held; exp_t e;
        drive_req(1'b0, 32'h0000_00F0, 32'h0000_000F, 2'b11);
        drive_req(1'b1, 32'h0000_0010, 32'h0000_0020, 2'b00);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b1;
        #1;
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_first_grant: got ready1/0=%b want 01", {bus.req1_ready, bus.req0_ready});
        end
        push_exp(1'b0, 32'h0000_00FF);
        step();
        bus.req0_valid = 1'b0;
        wait_rsp(ok, p, held, rc);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (!ok || {bus.rsp0_valid, bus.rsp1_valid, bus.req1_ready, busy} !== 4'b1001
                || bus.rsp0_y !== held) begin
                errors++;
                $display("FAIL bp_hold_%0d: got rv0/rv1/rdy1/busy=%b y=%h want 1001 y=%h",
                         i, {bus.rsp0_valid, bus.rsp1_valid, bus.req1_ready, busy},
                         bus.rsp0_y, held);
            end
            step();
            #1;
        end
        bus.rsp0_ready = 1'b1;
        e = pop_exp();
        checks++;
        if (!e.vld || bus.rsp0_valid !== 1'b1 || e.port !== 1'b0 || bus.rsp0_y !== e.y) begin
            errors++;
            $display("FAIL bp_result: got rv0=%b y=%h want rv0=1 y=%h", bus.rsp0_valid, bus.rsp0_y, e.y);
        end
        step();
        checks++;
        if ({busy, bus.req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: got busy/rdy1=%b want 01", {busy, bus.req1_ready});
        end
        push_exp(1'b1, 32'h0000_0030);
        step();
        bus.req1_valid = 1'b0;
        wait_rsp(ok, p, y, rc);
        e = pop_exp();
        checks++;
        if (!ok || !e.vld || p !== e.port || y !== e.y) begin
            errors++;
            $display("FAIL bp_req1_result: got port=%b y=%h want port=%b y=%h", p, y, e.port, e.y);
        end
        step();
    endtask

    task automatic test_reset_midop();
        bit ok; int acc; int rc; logic p; logic [31:0] y; exp_t e;
        send(1'b0, 32'h0000_0005, 32'h0000_0007, 2'b01, 32'hFFFF_FFFE, ok, acc);
        wait_rsp(ok, p, y, rc);
        e = pop_exp();
        checks++;
        if (!ok || !e.vld || p !== e.port || y !== e.y) begin
            errors++;
            $display("FAIL midop_setup: got port=%b y=%h want port=%b y=%h", p, y, e.port, e.y);
        end
        step();
        send(1'b1, 32'h0000_0001, 32'h0000_0001, 2'b00, 32'h0000_0002, ok, acc);
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb.pop_back());
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin
                errors++;
                $display("FAIL midop_abandon_%0d: got busy/rv0/rv1=%b want 000",
                         i, {busy, bus.rsp0_valid, bus.rsp1_valid});
            end
            step();
        end
        drive_req(1'b0, 32'h0000_0009, 32'h0000_0003, 2'b10);
        drive_req(1'b1, 32'h0000_0009, 32'h0000_0003, 2'b11);
        #1;
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL midop_prio: got ready1/0=%b want 01", {bus.req1_ready, bus.req0_ready});
        end
        push_exp(1'b0, 32'h0000_0001);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_rsp(ok, p, y, rc);
        e = pop_exp();
        checks++;
        if (!ok || !e.vld || p !== e.port || y !== e.y) begin
            errors++;
            $display("FAIL midop_after: got port=%b y=%h want port=%b y=%h", p, y, e.port, e.y);
        end
        step();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_single_op();
        test_opcodes();
        test_contention();
        test_backpressure();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1);
    end
endmodule
`default_nettype wire
